// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared GPMC state encoding and default timing constants (master and slave side)
package gpmc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_TURN,
      S_DATA,
      S_HOLD
   } gpmc_state_t;

   localparam int CNT_W             = 4;
   localparam int DEF_DATA_WIDTH    = 16;
   localparam int DEF_ADV_CYCLES    = 2;
   localparam int DEF_ACCESS_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES   = 2;

   // phase counter counts down to zero, so an N-cycle phase loads N-1
   function automatic logic [CNT_W-1:0] phase_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/gpmc_phase_cnt.sv
// gpmc_phase_cnt: 4-bit load/decrement phase timer, done when the count reaches zero
module gpmc_phase_cnt
   import gpmc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   // reload on phase entry, otherwise count down and park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/gpmc_master.sv
// gpmc_master: GPMC multiplexed AD bus master; GPMC_MASTER_CLK_EN enables a clk/2 gpmc_clk during transactions
module gpmc_master
   import gpmc_pkg::*;
#(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADV_CYCLES    = DEF_ADV_CYCLES,
   parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [DATA_WIDTH-1:0] gpmc_ad_out,
   output logic                  gpmc_ad_oe,
   input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
   output logic                  gpmc_advn,
   output logic                  gpmc_csn1,
   output logic                  gpmc_wein,
   output logic                  gpmc_oen,
   output logic                  gpmc_clk
);

   gpmc_state_t           state, state_next;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  accept, load, done, rd_done;
   logic [CNT_W-1:0]      load_val;

   assign accept  = req_valid && req_ready;
   assign rd_done = (state == S_DATA) && done && !wr_q;

   // state register; reset drops straight to IDLE, aborting any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // phase sequencing; reads insert a one-cycle bus turnaround before DATA
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  state_next = accept ? S_ADDR : S_IDLE;
         S_ADDR:  state_next = done ? (wr_q ? S_DATA : S_TURN) : S_ADDR;
         S_TURN:  state_next = S_DATA;
         S_DATA:  state_next = done ? S_HOLD : S_DATA;
         S_HOLD:  state_next = done ? S_IDLE : S_HOLD;
         default: state_next = S_IDLE;
      endcase
   end

   // reload the phase timer whenever a new state is entered
   always_comb begin
      load     = (state_next != state);
      load_val = (state_next == S_ADDR) ? phase_load(ADV_CYCLES)    :
                 (state_next == S_DATA) ? phase_load(ACCESS_CYCLES) :
                 (state_next == S_HOLD) ? phase_load(HOLD_CYCLES)   : '0;
   end

   gpmc_phase_cnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   // capture the request on acceptance so later input changes are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // read data is taken on the edge closing the last strobe cycle and pulsed out once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= rd_done;
         if (rd_done)
            rsp_rdata <= gpmc_ad_in;
      end
   end

   // bus pin levels are a pure function of the current phase and the latched request
   always_comb begin
      req_ready   = rst_n && (state == S_IDLE);
      gpmc_csn1   = 1'b1;
      gpmc_advn   = 1'b1;
      gpmc_wein   = 1'b1;
      gpmc_oen    = 1'b1;
      gpmc_ad_oe  = 1'b0;
      gpmc_ad_out = '0;
      case (state)
         S_ADDR: begin
            gpmc_csn1   = 1'b0;
            gpmc_advn   = 1'b0;
            gpmc_ad_oe  = 1'b1;
            gpmc_ad_out = DATA_WIDTH'(addr_q);
         end
         S_TURN: gpmc_csn1 = 1'b0;
         S_DATA: begin
            gpmc_csn1   = 1'b0;
            gpmc_wein   = !wr_q;
            gpmc_oen    = wr_q;
            gpmc_ad_oe  = wr_q;
            gpmc_ad_out = wr_q ? wdata_q : '0;
         end
         S_HOLD: begin
            gpmc_csn1   = 1'b0;
            gpmc_ad_oe  = wr_q;
            gpmc_ad_out = wr_q ? wdata_q : '0;
         end
         default: ;
      endcase
   end

`ifdef GPMC_MASTER_CLK_EN
   logic gclk_q;

   // clk/2 bus clock: low on ADDR entry, toggling each cycle, forced low in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gclk_q <= 1'b0;
      else
         gclk_q <= (state == S_IDLE || state_next == S_IDLE) ? 1'b0 : !gclk_q;
   end

   assign gpmc_clk = gclk_q;
`else
   assign gpmc_clk = 1'b0;
`endif

endmodule

// File: tb/tb_gpmc_master.sv
// tb_gpmc_master: scoreboard bench for gpmc_master; expected pin timeline built per accepted request
module tb_gpmc_master;

   localparam int ADV = 2;
   localparam int ACC = 4;
   localparam int HLD = 2;

   typedef struct packed {
      logic        ready, csn1, advn, wein, oen, ad_oe;
      logic [15:0] ad;
      logic        rv, gclk, smp;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [4:0]  req_addr = '0;
   logic [15:0] req_wdata = '0, gpmc_ad_in = '0;
   logic        req_ready, rsp_valid, gpmc_ad_oe, gpmc_advn, gpmc_csn1, gpmc_wein, gpmc_oen, gpmc_clk;
   logic [15:0] rsp_rdata, gpmc_ad_out;

   rec_t        expq[$];
   logic [15:0] rspq[$];
   logic [15:0] last_rdata = '0;
   logic        ad_fix = 1'b0;
   int          n_chk = 0, n_fail = 0;

   localparam rec_t IDLE_RDY = '{ready:1'b1, csn1:1'b1, advn:1'b1, wein:1'b1, oen:1'b1, ad_oe:1'b0, ad:16'h0, rv:1'b0, gclk:1'b0, smp:1'b0};
   localparam rec_t IDLE_RST = '{ready:1'b0, csn1:1'b1, advn:1'b1, wein:1'b1, oen:1'b1, ad_oe:1'b0, ad:16'h0, rv:1'b0, gclk:1'b0, smp:1'b0};

   gpmc_master #(
      .ADDR_WIDTH    (5),
      .DATA_WIDTH    (16),
      .ADV_CYCLES    (ADV),
      .ACCESS_CYCLES (ACC),
      .HOLD_CYCLES   (HLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .gpmc_ad_out (gpmc_ad_out),
      .gpmc_ad_oe  (gpmc_ad_oe),
      .gpmc_ad_in  (gpmc_ad_in),
      .gpmc_advn   (gpmc_advn),
      .gpmc_csn1   (gpmc_csn1),
      .gpmc_wein   (gpmc_wein),
      .gpmc_oen    (gpmc_oen),
      .gpmc_clk    (gpmc_clk)
   );

   always #5 clk = !clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic gck(input int i);
`ifdef GPMC_MASTER_CLK_EN
      return (i % 2) == 1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic rec_t mk(input logic advn, wein, oen, oe, input logic [15:0] ad, input logic rv, input int i, input logic smp);
      return '{ready:1'b0, csn1:1'b0, advn:advn, wein:wein, oen:oen, ad_oe:oe, ad:ad, rv:rv, gclk:gck(i), smp:smp};
   endfunction

   // expected pin timeline of one transaction, cycle by cycle from the first address cycle
   task automatic push_txn(input logic wr, input logic [15:0] ad, input logic [15:0] wd);
      int i = 0;
      for (int k = 0; k < ADV; k++) expq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, ad, 1'b0, i++, 1'b0));
      if (!wr) expq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, i++, 1'b0));
      for (int k = 0; k < ACC; k++) expq.push_back(mk(1'b1, !wr, wr, wr, wr ? wd : 16'h0, 1'b0, i++, !wr && k == ACC - 1));
      for (int k = 0; k < HLD; k++) expq.push_back(mk(1'b1, 1'b1, 1'b1, wr, wr ? wd : 16'h0, !wr && k == 0, i++, 1'b0));
   endtask

   // present a request and hold it until accepted; optionally scramble the payload while not ready
   task automatic issue(input logic wr, input logic [4:0] a, input logic [15:0] d, input logic jitter);
      bit ok = 0;
      @(posedge clk) #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk) #1;
         if (req_ready) begin
            push_txn(req_write, 16'(req_addr), req_wdata);
            ok = 1;
            break;
         end
         if (jitter) begin
            req_write = 1'($urandom);
            req_addr  = 5'($urandom);
            req_wdata = 16'($urandom);
         end
      end
      if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic idle(input int n);
      @(posedge clk) #1;
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && expq.size() != 0; k++) @(negedge clk);
      chk("drain_timeout", 32'(expq.size()), 32'd0);
   endtask

   // read-side slave model: fresh AD data every cycle unless a fixed pattern is requested
   always @(posedge clk) begin
      #1;
      gpmc_ad_in = ad_fix ? 16'h1234 : 16'($urandom);
   end

   // monitor: compare pins every cycle against the timeline, and read data whenever rsp_valid shows
   always @(negedge clk) begin
      rec_t e, a;
      a = '{ready:req_ready, csn1:gpmc_csn1, advn:gpmc_advn, wein:gpmc_wein, oen:gpmc_oen, ad_oe:gpmc_ad_oe,
            ad:gpmc_ad_out, rv:rsp_valid, gclk:gpmc_clk, smp:1'b0};
      if (!rst_n) begin
         expq.delete();
         rspq.delete();
         last_rdata = '0;
         e = IDLE_RST;
      end else if (expq.size() != 0) begin
         e = expq.pop_front();
         if (e.smp) rspq.push_back(gpmc_ad_in);
         e.smp = 1'b0;
      end else begin
         e = IDLE_RDY;
      end
      if (rst_n && !e.ad_oe) a.ad = e.ad;
      chk("pins", 32'(a), 32'(e));
      if (rst_n && rsp_valid) begin
         if (rspq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         else last_rdata = rspq.pop_front();
         chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
      end else begin
         chk("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // directed write then read with fixed slave data
      issue(1'b1, 5'h03, 16'hA5C3, 1'b0);
      idle(2);
      ad_fix = 1'b1;
      issue(1'b0, 5'h04, 16'h0000, 1'b0);
      idle(0);
      drain();
      ad_fix = 1'b0;
      repeat (2) @(posedge clk);

      // back-to-back with valid held high, payload scrambled while waiting
      issue(1'b1, 5'h1F, 16'hFFFF, 1'b0);
      issue(1'b0, 5'h11, 16'h0000, 1'b1);
      issue(1'b1, 5'h00, 16'h0000, 1'b1);
      idle(0);
      drain();

      // read aborted by reset in its second strobe cycle
      issue(1'b0, 5'h0A, 16'h0000, 1'b0);
      @(posedge clk) #1;
      req_valid = 1'b0;
      repeat (ADV + 2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_pins", 32'({req_ready, gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_ad_oe, gpmc_ad_out, rsp_valid, gpmc_clk}),
             32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0}));
      chk("async_reset_rdata", 32'(rsp_rdata), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // randomized mix of reads/writes, gaps and held-valid bursts
      for (int t = 0; t < 40; t++) begin
         int gap;
         issue(1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom));
         gap = $urandom_range(0, 2);
         if (gap != 0) idle(gap - 1);
      end
      idle(0);
      drain();
      repeat (3) @(negedge clk);
      chk("rsp_queue_empty", 32'(rspq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
